riscv_wbuf_coalesce: RTL and testbench

Parametrised data-side write buffer between the CPU load/store unit and the data-cache core, with a configurable depth.
Compared with the plain write buffer, it adds three things:
- write coalescing into the youngest entry;
- store-to-load forwarding;
- ordered cache-flush pass-through.
It also exports occupancy status. It sits after the misalignment check and before the dcache/nodcache core.

---
 rtl/riscv_wbuf_coalesce.sv | 212 +++++++++++++++++++++
 tb/tb_riscv_wbuf_coalesce.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wbuf_coalesce.sv
// Data-side write buffer between the LSU and the dcache core: a circular FIFO of
// word-granular stores with youngest-entry coalescing, store-to-load forwarding and ordered flush.
module riscv_wbuf_coalesce #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 8,
  parameter bit COALESCE = 1'b1,
  parameter bit FORWARD  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       mem_req_i,
  input  logic [XLEN-1:0]            mem_adr_i,
  input  logic [XLEN-1:0]            mem_d_i,
  input  logic                       mem_we_i,
  input  logic [XLEN/8-1:0]          mem_be_i,
  input  logic [1:0]                 mem_prv_i,
  input  logic                       mem_flush_i,
  output logic [XLEN-1:0]            mem_q_o,
  output logic                       mem_ack_o,
  output logic                       cache_req_o,
  output logic [XLEN-1:0]            cache_adr_o,
  output logic [XLEN-1:0]            cache_d_o,
  output logic                       cache_we_o,
  output logic [XLEN/8-1:0]          cache_be_o,
  output logic [1:0]                 cache_prv_o,
  output logic                       cache_flush_o,
  input  logic [XLEN-1:0]            cache_q_i,
  input  logic                       cache_ack_i,
  output logic                       wbuf_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] wbuf_level_o
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int WA  = XLEN - OFF;
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, READ, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [LW-1:0]   count_q, count_d;

  logic [WA-1:0]   entAdr_q  [DEPTH];
  logic [XLEN-1:0] entData_q [DEPTH];
  logic [NB-1:0]   entBe_q   [DEPTH];
  logic [1:0]      entPrv_q  [DEPTH];

  logic [WA-1:0]   reqWadr;
  logic [PW-1:0]   youngIdx;
  logic            wrReq;
  logic            rdReq;
  logic            headIssued;
  logic            doCoalesce;
  logic            doPush;
  logic            doPop;
  logic            fwdHit;
  logic            rdMiss;
  logic [PW-1:0]   fwdIdx;
  logic [LW-1:0]   nMatch;

  function automatic logic entryValid(input logic [PW-1:0] idx,
                                      input logic [PW-1:0] head,
                                      input logic [LW-1:0] cnt);
    logic [PW-1:0] rel;
    rel = idx - head;
    return LW'(rel) < cnt;
  endfunction

  assign reqWadr  = mem_adr_i[XLEN-1:OFF];
  assign youngIdx = tail_q - PW'(1);
  assign wrReq    = mem_req_i & mem_we_i & ~mem_flush_i;
  assign rdReq    = mem_req_i & ~mem_we_i & ~mem_flush_i;

  // Forwarding is only safe when exactly one buffered entry holds this word.
  always_comb begin
    nMatch = '0;
    fwdIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid(PW'(i), head_q, count_q) && entAdr_q[i] == reqWadr) begin
        nMatch = nMatch + LW'(1);
        fwdIdx = PW'(i);
      end
    end
  end

  assign fwdHit = FORWARD && rdReq && (nMatch == LW'(1)) &&
                  ((entBe_q[fwdIdx] & mem_be_i) == mem_be_i);
  assign rdMiss = rdReq & ~fwdHit;

  // The head held on cache_req must stay stable, so it is never a coalesce target.
  assign headIssued = (state_q == DRAIN) && (youngIdx == head_q);
  assign doCoalesce = COALESCE && wrReq && (count_q != '0) &&
                      (entAdr_q[youngIdx] == reqWadr) && !headIssued;
  assign doPush     = wrReq && !doCoalesce && (count_q != LW'(DEPTH));
  assign doPop      = (state_q == DRAIN) && cache_ack_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (doPush) begin
      tail_d = tail_q + PW'(1);
    end
    if (doPop) begin
      head_d = head_q + PW'(1);
    end
    if (doPush && !doPop) begin
      count_d = count_q + LW'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - LW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_q_o       = '0;
    mem_ack_o     = doCoalesce | doPush | fwdHit;
    cache_req_o   = 1'b0;
    cache_adr_o   = '0;
    cache_d_o     = '0;
    cache_we_o    = 1'b0;
    cache_be_o    = '0;
    cache_prv_o   = '0;
    cache_flush_o = 1'b0;
    if (fwdHit) begin
      mem_q_o = entData_q[fwdIdx];
    end
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = DRAIN;
        end else if (mem_flush_i) begin
          state_d = FLUSH;
        end else if (rdMiss) begin
          state_d = READ;
        end
      end
      DRAIN: begin
        cache_req_o = 1'b1;
        cache_we_o  = 1'b1;
        cache_adr_o = {entAdr_q[head_q], {OFF{1'b0}}};
        cache_d_o   = entData_q[head_q];
        cache_be_o  = entBe_q[head_q];
        cache_prv_o = entPrv_q[head_q];
        if (cache_ack_i && count_d == '0) begin
          state_d = IDLE;
        end
      end
      READ: begin
        cache_req_o = 1'b1;
        cache_adr_o = mem_adr_i;
        cache_be_o  = mem_be_i;
        cache_prv_o = mem_prv_i;
        mem_q_o     = cache_q_i;
        mem_ack_o   = mem_ack_o | cache_ack_i;
        if (cache_ack_i) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        cache_req_o   = 1'b1;
        cache_flush_o = 1'b1;
        cache_prv_o   = mem_prv_i;
        mem_ack_o     = mem_ack_o | cache_ack_i;
        if (cache_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: nothing reads an entry outside the valid window.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      entAdr_q[tail_q]  <= reqWadr;
      entData_q[tail_q] <= mem_d_i;
      entBe_q[tail_q]   <= mem_be_i;
      entPrv_q[tail_q]  <= mem_prv_i;
    end
    if (doCoalesce) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be_i[b]) begin
          entData_q[youngIdx][8*b +: 8] <= mem_d_i[8*b +: 8];
        end
      end
      entBe_q[youngIdx]  <= entBe_q[youngIdx] | mem_be_i;
      entPrv_q[youngIdx] <= mem_prv_i;
    end
  end

  assign wbuf_level_o = count_q;
  assign wbuf_empty_o = (count_q == '0);

endmodule

// File: tb/tb_riscv_wbuf_coalesce.sv
// Self-checking bench for riscv_wbuf_coalesce: directed scenarios plus random traffic,
// every cycle compared against a queue-based transaction model of the buffer.
module tb_riscv_wbuf_coalesce;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_flush;
  logic [31:0] mem_adr, mem_d, mem_q;
  logic [3:0]  mem_be;
  logic [1:0]  mem_prv;
  logic        mem_ack;
  logic        cache_req, cache_we, cache_flush, cache_ack;
  logic [31:0] cache_adr, cache_d, cache_q;
  logic [3:0]  cache_be;
  logic [1:0]  cache_prv;
  logic        wbuf_empty;
  logic [3:0]  wbuf_level;

  always #5 clk = ~clk;

  riscv_wbuf_coalesce #(.XLEN(XLEN), .DEPTH(DEPTH), .COALESCE(1'b1), .FORWARD(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req_i(mem_req), .mem_adr_i(mem_adr), .mem_d_i(mem_d), .mem_we_i(mem_we),
    .mem_be_i(mem_be), .mem_prv_i(mem_prv), .mem_flush_i(mem_flush),
    .mem_q_o(mem_q), .mem_ack_o(mem_ack),
    .cache_req_o(cache_req), .cache_adr_o(cache_adr), .cache_d_o(cache_d),
    .cache_we_o(cache_we), .cache_be_o(cache_be), .cache_prv_o(cache_prv),
    .cache_flush_o(cache_flush), .cache_q_i(cache_q), .cache_ack_i(cache_ack),
    .wbuf_empty_o(wbuf_empty), .wbuf_level_o(wbuf_level)
  );

  typedef struct packed {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  prv;
  } entry_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] adr;
    logic [31:0] d;
    logic [3:0]  be;
    logic [1:0]  prv;
  } op_t;

  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_FL = 2'd2;

  entry_t      mq[$];
  op_t         opQ[$];
  op_t         cur;
  bit          active;
  bit          mDrain, mRead, mFlush;
  bit          fixedQ;
  logic [31:0] cacheQVal;
  int          nChecks, nFails;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic op_t mkOp(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be);
    op_t o;
    o.kind = k; o.adr = a; o.d = d; o.be = be; o.prv = 2'd3;
    return o;
  endfunction

  function automatic logic [31:0] beMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // One clock cycle: drive at negedge, compare with the model, then advance the model.
  task automatic applyStimulus(input bit doRst, input bit ackNow);
    bit          expReq, expAck, isWr, isRd, isFl, coal, push, fwd;
    logic [31:0] expQ;
    logic [29:0] w;
    int          nm, mi, oldSize;
    entry_t      e;
    @(negedge clk);
    rst = doRst;
    if (!active && !doRst && opQ.size() > 0) begin
      cur = opQ.pop_front();
      active = 1'b1;
    end
    isWr = active && cur.kind == OP_WR;
    isRd = active && cur.kind == OP_RD;
    isFl = active && cur.kind == OP_FL;
    mem_req   = isWr || isRd;
    mem_we    = isWr;
    mem_flush = isFl;
    mem_adr   = active ? cur.adr : 32'h0;
    mem_d     = active ? cur.d : 32'h0;
    mem_be    = active ? cur.be : 4'h0;
    mem_prv   = active ? cur.prv : 2'd0;
    cache_q   = fixedQ ? cacheQVal : $urandom;
    w         = cur.adr[31:2];
    expReq    = mDrain || mRead || mFlush;
    cache_ack = ackNow && expReq;

    coal = 0; push = 0; fwd = 0; expAck = 0; expQ = '0; nm = 0; mi = 0;
    foreach (mq[i]) if (mq[i].w == w) begin nm++; mi = i; end
    if (isWr) begin
      coal = mq.size() > 0 && mq[mq.size()-1].w == w && !(mDrain && mq.size() == 1);
      push = !coal && mq.size() < DEPTH;
      expAck = coal || push;
    end else if (isRd) begin
      fwd = (nm == 1) && ((mq[mi].be & cur.be) == cur.be);
      if (fwd) begin
        expAck = 1; expQ = mq[mi].d;
      end else if (mRead) begin
        expAck = cache_ack; expQ = cache_q;
      end
    end else if (isFl) begin
      expAck = mFlush && cache_ack;
    end

    #1;
    checkOutput("mem_ack", mem_ack, expAck);
    if (expAck && isRd) checkOutput("mem_q", mem_q, expQ);
    checkOutput("level", wbuf_level, mq.size());
    checkOutput("empty", wbuf_empty, mq.size() == 0);
    checkOutput("cache_req", cache_req, expReq);
    checkOutput("cache_flush", cache_flush, mFlush);
    if (mDrain) begin
      checkOutput("drain_we", cache_we, 1);
      checkOutput("drain_adr", cache_adr, {mq[0].w, 2'b00});
      checkOutput("drain_be", cache_be, mq[0].be);
      checkOutput("drain_prv", cache_prv, mq[0].prv);
      checkOutput("drain_d", cache_d & beMask(mq[0].be), mq[0].d & beMask(mq[0].be));
    end else if (mRead) begin
      checkOutput("read_we", cache_we, 0);
      checkOutput("read_adr", cache_adr, cur.adr);
      checkOutput("read_be", cache_be, cur.be);
    end

    if (doRst) begin
      mq.delete();
      mDrain = 0; mRead = 0; mFlush = 0; active = 0;
    end else begin
      oldSize = mq.size();
      if (coal) begin
        e = mq[mq.size()-1];
        for (int b = 0; b < 4; b++) if (cur.be[b]) e.d[8*b +: 8] = cur.d[8*b +: 8];
        e.be  = e.be | cur.be;
        e.prv = cur.prv;
        mq[mq.size()-1] = e;
      end
      if (push) mq.push_back({w, cur.d, cur.be, cur.prv});
      if (mDrain) begin
        if (cache_ack) void'(mq.pop_front());
        if (mq.size() == 0) mDrain = 0;
      end else if (mRead) begin
        if (cache_ack) mRead = 0;
      end else if (mFlush) begin
        if (cache_ack) mFlush = 0;
      end else if (oldSize > 0) begin
        mDrain = 1;
      end else if (isFl) begin
        mFlush = 1;
      end else if (isRd && !fwd) begin
        mRead = 1;
      end
      if (expAck) active = 0;
    end
  endtask

  task automatic peekState(input string tag, input int lvl, input bit req);
    @(posedge clk);
    #1;
    checkOutput({tag, "_level"}, wbuf_level, lvl);
    checkOutput({tag, "_req"}, cache_req, req);
  endtask

  task automatic drainAll();
    int n;
    n = 0;
    while ((active || opQ.size() > 0 || mDrain || mRead || mFlush || mq.size() > 0) && n < 300) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    checkOutput("drain_timeout", n < 300, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; mem_req = 0; mem_we = 0; mem_flush = 0; mem_adr = 0; mem_d = 0;
    mem_be = 0; mem_prv = 0; cache_ack = 0; cache_q = 0;
    active = 0; mDrain = 0; mRead = 0; mFlush = 0; fixedQ = 0; cacheQVal = 0;
    nChecks = 0; nFails = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_empty", wbuf_empty, 1);
    checkOutput("rst_level", wbuf_level, 0);
    checkOutput("rst_req", cache_req, 0);
    checkOutput("rst_ack", mem_ack, 0);
    applyStimulus(1'b1, 1'b0);

    // Single write held on the cache for three cycles before the ack.
    opQ.push_back(mkOp(OP_WR, 32'h100, 32'hAABBCCDD, 4'hF));
    applyStimulus(1'b0, 1'b0);
    peekState("w100", 1, 0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    peekState("w100_drain", 1, 1);
    checkOutput("w100_adr", cache_adr, 32'h100);
    applyStimulus(1'b0, 1'b1);
    peekState("w100_done", 0, 0);

    // Two byte writes to one word merge into a single entry.
    opQ.push_back(mkOp(OP_WR, 32'h200, 32'h11, 4'h1));
    opQ.push_back(mkOp(OP_WR, 32'h200, 32'h2200, 4'h2));
    repeat (2) applyStimulus(1'b0, 1'b0);
    peekState("coal", 1, 1);
    checkOutput("coal_be", cache_be, 4'h3);
    checkOutput("coal_d", cache_d[15:0], 16'h2211);
    drainAll();

    // Fill to DEPTH, ninth write waits for the first pop.
    for (int i = 0; i < 9; i++) opQ.push_back(mkOp(OP_WR, 32'h1000 + 32'(4*i), 32'(i), 4'hF));
    repeat (12) applyStimulus(1'b0, 1'b0);
    peekState("full", 8, 1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    peekState("full_after", 8, 1);
    drainAll();

    // Fully covered read forwards; partially covered read waits for drain.
    opQ.push_back(mkOp(OP_WR, 32'h300, 32'h12345678, 4'hF));
    opQ.push_back(mkOp(OP_RD, 32'h300, 32'h0, 4'h3));
    drainAll();
    fixedQ = 1; cacheQVal = 32'hDEADBEEF;
    opQ.push_back(mkOp(OP_WR, 32'h400, 32'h55, 4'h1));
    opQ.push_back(mkOp(OP_RD, 32'h400, 32'h0, 4'hF));
    drainAll();
    fixedQ = 0;

    // Flush follows buffered writes; reset mid-drain discards everything.
    opQ.push_back(mkOp(OP_WR, 32'h500, 32'h1, 4'hF));
    opQ.push_back(mkOp(OP_WR, 32'h504, 32'h2, 4'hF));
    opQ.push_back(mkOp(OP_FL, 32'h0, 32'h0, 4'h0));
    drainAll();
    opQ.push_back(mkOp(OP_WR, 32'h600, 32'h3, 4'hF));
    opQ.push_back(mkOp(OP_WR, 32'h604, 32'h4, 4'hF));
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    peekState("rst_mid", 0, 0);
    checkOutput("rst_mid_empty", wbuf_empty, 1);

    // Random traffic over a small address pool to exercise matches.
    for (int n = 0; n < 3000; n++) begin
      if (!active && opQ.size() == 0 && $urandom_range(99) < 70) begin
        op_t o;
        int r;
        r = $urandom_range(9);
        o.kind = (r < 6) ? OP_WR : (r < 9) ? OP_RD : OP_FL;
        o.adr  = ($urandom_range(7) == 0) ? $urandom : 32'h2000 + 32'(4 * $urandom_range(3));
        o.adr  = (o.kind == OP_RD) ? o.adr : {o.adr[31:2], 2'b00};
        o.d    = $urandom;
        o.be   = 4'($urandom_range(15, 1));
        o.prv  = 2'($urandom_range(3));
        opQ.push_back(o);
      end
      applyStimulus($urandom_range(999) == 0, $urandom_range(99) < 40);
    end
    drainAll();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
